// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: hazard inputs and pipeline enable/flush outputs for the stall controller.
// Revision 1.0
`default_nettype none

interface hazard_stall_ctrl_if;
  logic        branch_load_dstall;
  logic        load_use_dstall;
  logic        branch_taken;
  logic        dmem_req;
  logic        dmem_ready;
  logic        PC_EN;
  logic        IF_ID_EN;
  logic        IF_ID_flush;
  logic        ID_EX_EN;
  logic        ID_EX_flush;
  logic        EX_MEM_EN;
  logic [15:0] stall_cycles;

  modport master (
    output branch_load_dstall, load_use_dstall, branch_taken, dmem_req, dmem_ready,
    input  PC_EN, IF_ID_EN, IF_ID_flush, ID_EX_EN, ID_EX_flush, EX_MEM_EN, stall_cycles
  );

  modport slave (
    input  branch_load_dstall, load_use_dstall, branch_taken, dmem_req, dmem_ready,
    output PC_EN, IF_ID_EN, IF_ID_flush, ID_EX_EN, ID_EX_flush, EX_MEM_EN, stall_cycles
  );
endinterface

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline stall/flush controller for load hazards, taken branches and memory waits.
// Revision 1.0
`default_nettype none

module hazard_stall_ctrl (
  input  wire                   clk,
  input  wire                   rst,
  hazard_stall_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BL_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  state_t      resume_q, resume_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic w_mem_wait;
  logic w_pc_en, w_if_id_en, w_if_id_flush, w_id_ex_en, w_id_ex_flush, w_ex_mem_en;

  assign w_mem_wait = bus.dmem_req & ~bus.dmem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      resume_q    <= RUN;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      resume_q    <= resume_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    resume_d      = resume_q;
    w_pc_en       = 1'b1;
    w_if_id_en    = 1'b1;
    w_if_id_flush = 1'b0;
    w_id_ex_en    = 1'b1;
    w_id_ex_flush = 1'b0;
    w_ex_mem_en   = 1'b1;

    case (state_q)
      RUN: begin
        if (w_mem_wait) begin
          {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en} = 4'b0000;
          resume_d = RUN;
          state_d  = MEM_WAIT;
        end else if (bus.branch_load_dstall || bus.load_use_dstall) begin
          // Hold PC and IF/ID, push a bubble into ID/EX; older stages keep draining.
          w_pc_en       = 1'b0;
          w_if_id_en    = 1'b0;
          w_id_ex_flush = 1'b1;
          if (bus.branch_load_dstall) state_d = BL_STALL;
        end else if (bus.branch_taken) begin
          w_if_id_flush = 1'b1;
        end
      end

      BL_STALL: begin
        if (w_mem_wait) begin
          {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en} = 4'b0000;
          resume_d = BL_STALL;
          state_d  = MEM_WAIT;
        end else begin
          w_pc_en       = 1'b0;
          w_if_id_en    = 1'b0;
          w_id_ex_flush = 1'b1;
          state_d       = RUN;
        end
      end

      MEM_WAIT: begin
        // The completing cycle is still frozen; the interrupted state resumes next edge.
        {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en} = 4'b0000;
        if (!w_mem_wait) state_d = resume_q;
      end

      default: begin
        state_d  = RUN;
        resume_d = RUN;
      end
    endcase

    if (rst) begin
      {w_pc_en, w_if_id_en, w_if_id_flush, w_id_ex_en, w_id_ex_flush, w_ex_mem_en} = 6'b000000;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!w_pc_en && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  assign bus.PC_EN        = w_pc_en;
  assign bus.IF_ID_EN     = w_if_id_en;
  assign bus.IF_ID_flush  = w_if_id_flush;
  assign bus.ID_EX_EN     = w_id_ex_en;
  assign bus.ID_EX_flush  = w_id_ex_flush;
  assign bus.EX_MEM_EN    = w_ex_mem_en;
  assign bus.stall_cycles = stall_cnt_q;

endmodule

`default_nettype wire
